// File: rtl/fx_pkg.sv
// Shared fixed-point constants and sequencing state encoding for the
// sequential fixed-point units (multiplier, divider, integrator).
package fx_pkg;

    localparam int FX_WIDTH = 32;
    localparam int FX_FRAC  = 21;

    localparam logic [FX_WIDTH-1:0] FX_ONE = 32'h0020_0000;
    localparam logic [FX_WIDTH-1:0] FX_MAX = 32'h7FFF_FFFF;
    localparam logic [FX_WIDTH-1:0] FX_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fx_state_e;

endpackage

// File: rtl/fixed_mult_seq_if.sv
// Start/valid handshake and operand/result bus of the sequential multiplier.
interface fixed_mult_seq_if
    import fx_pkg::*;
#(
    parameter int Width = FX_WIDTH
) ();

    logic             start_i;
    logic [Width-1:0] a_i;
    logic [Width-1:0] b_i;
    logic [Width-1:0] prod_o;
    logic             valid_o;
    logic             busy_o;
    logic             sat_o;

    modport master (
        output start_i, a_i, b_i,
        input  prod_o, valid_o, busy_o, sat_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output prod_o, valid_o, busy_o, sat_o
    );

endinterface

// File: rtl/fx_sat.sv
// Converts a wide truncated magnitude plus sign into a Width-bit two's
// complement value, clipping to the representable range.
module fx_sat
    import fx_pkg::*;
#(
    parameter int Width = FX_WIDTH,
    parameter int Frac  = FX_FRAC
) (
    input  logic [2*Width-Frac-1:0] mag_i,
    input  logic                    sign_i,
    output logic [Width-1:0]        res_o,
    output logic                    sat_o
);

    localparam int MagW = 2*Width - Frac;
    localparam logic [MagW-1:0]  ONE_W   = {{(MagW-1){1'b0}}, 1'b1};
    localparam logic [MagW-1:0]  NEG_LIM = ONE_W << (Width-1);
    localparam logic [MagW-1:0]  POS_LIM = NEG_LIM - ONE_W;
    localparam logic [Width-1:0] RES_MAX = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] RES_MIN = {1'b1, {(Width-1){1'b0}}};

    logic [Width-1:0] mag_lo;
    assign mag_lo = mag_i[Width-1:0];

    // Negating a zero magnitude wraps back to zero, so no -0 can appear.
    always_comb begin
        res_o = '0;
        sat_o = 1'b0;
        if (sign_i) begin
            if (mag_i > NEG_LIM) begin
                res_o = RES_MIN;
                sat_o = 1'b1;
            end else begin
                res_o = -mag_lo;
            end
        end else begin
            if (mag_i > POS_LIM) begin
                res_o = RES_MAX;
                sat_o = 1'b1;
            end else begin
                res_o = mag_lo;
            end
        end
    end

endmodule

// File: rtl/fixed_mult_seq.sv
// Radix-2 shift-add signed fixed-point multiplier, one multiplier bit per clock.
//   state | meaning
//   IDLE  | waiting for start_i, result held
//   BUSY  | one shift-add iteration per cycle, Width cycles
//   DONE  | result presented, valid_o pulse
module fixed_mult_seq
    import fx_pkg::*;
#(
    parameter int Width = FX_WIDTH,
    parameter int Frac  = FX_FRAC
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    fixed_mult_seq_if.slave   bus
);

    localparam int CntW = $clog2(Width+1);
    localparam int MagW = 2*Width - Frac;

    fx_state_e          state_q, state_d;
    logic [2*Width-1:0] mcand_q, mcand_d;
    logic [Width-1:0]   mplier_q, mplier_d;
    logic [2*Width-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [Width-1:0]   prod_q, prod_d;
    logic               sat_q, sat_d;

    logic [Width-1:0]   a_mag, b_mag;
    logic [2*Width-1:0] acc_add;
    logic [Width-1:0]   sat_res;
    logic               sat_flag;
    logic               unused_frac;

    // Most-negative input negates to itself, which is the correct unsigned magnitude.
    assign a_mag = bus.a_i[Width-1] ? -bus.a_i : bus.a_i;
    assign b_mag = bus.b_i[Width-1] ? -bus.b_i : bus.b_i;

    assign acc_add     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign unused_frac = ^acc_add[Frac-1:0];

    fx_sat #(
        .Width (Width),
        .Frac  (Frac)
    ) u_sat (
        .mag_i  (acc_add[2*Width-1:Frac]),
        .sign_i (sign_q),
        .res_o  (sat_res),
        .sat_o  (sat_flag)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            prod_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            prod_q   <= prod_d;
            sat_q    <= sat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        prod_d   = prod_q;
        sat_d    = sat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    mcand_d  = {{Width{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    sign_d   = bus.a_i[Width-1] ^ bus.b_i[Width-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d    = acc_add;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Load the result on the last iteration so it is visible with valid_o.
                if (cnt_q == CntW'(Width-1)) begin
                    prod_d  = sat_res;
                    sat_d   = sat_flag;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.prod_o  = prod_q;
    assign bus.sat_o   = sat_q;
    assign bus.valid_o = (state_q == ST_DONE);
    assign bus.busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fixed_mult_seq.sv
// Directed bench for fixed_mult_seq: scoreboard of model results, checked on valid_o.
module tb_fixed_mult_seq;
    import fx_pkg::*;

    localparam int W       = FX_WIDTH;
    localparam int EXP_LAT = W;   // negedges from start-release to valid_o

    typedef struct {
        logic [W-1:0] prod;
        logic         sat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t sb[$];

    fixed_mult_seq_if #(.Width(W)) bus_if ();

    fixed_mult_seq #(.Width(W), .Frac(FX_FRAC)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p, mag, m;
        exp_t   e;
        p   = longint'($signed(a)) * longint'($signed(b));
        mag = (p < 0) ? -p : p;
        m   = mag >>> FX_FRAC;
        e.sat  = 1'b0;
        if (p < 0) begin
            if (m > 64'sd2147483648) begin
                e.prod = 32'h8000_0000;
                e.sat  = 1'b1;
            end else begin
                e.prod = 32'(-m);
            end
        end else begin
            if (m > 64'sd2147483647) begin
                e.prod = 32'h7FFF_FFFF;
                e.sat  = 1'b1;
            end else begin
                e.prod = 32'(m);
            end
        end
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb);
        int   lat;
        int   extra;
        exp_t e;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus_if.a_i     = a;
        bus_if.b_i     = b;
        bus_if.start_i = 1'b1;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        chk({tag, "_busy_start"}, 64'(bus_if.busy_o), 64'd1);
        lat = 0;
        while (!bus_if.valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
            if (disturb && lat == 5) begin
                bus_if.a_i     = 32'h7D00_0000;
                bus_if.b_i     = 32'h8000_0000;
                bus_if.start_i = 1'b1;
            end else if (disturb && lat == 6) begin
                bus_if.start_i = 1'b0;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(EXP_LAT));
        if (bus_if.valid_o) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_prod"}, 64'(bus_if.prod_o), 64'(e.prod));
                chk({tag, "_sat"}, 64'(bus_if.sat_o), 64'(e.sat));
                chk({tag, "_busy_valid"}, 64'(bus_if.busy_o), 64'd1);
                @(negedge clk);
                chk({tag, "_valid_pulse"}, 64'(bus_if.valid_o), 64'd0);
                chk({tag, "_busy_after"}, 64'(bus_if.busy_o), 64'd0);
                chk({tag, "_prod_held"}, 64'(bus_if.prod_o), 64'(e.prod));
                if (disturb) begin
                    extra = 0;
                    for (int i = 0; i < W + 4; i++) begin
                        @(negedge clk);
                        if (bus_if.valid_o) extra++;
                    end
                    chk({tag, "_extra_valid"}, 64'(extra), 64'd0);
                end
            end
        end
    endtask

    initial begin
        int lat;
        int extra;
        tests_run      = 0;
        tests_failed   = 0;
        rst_n          = 1'b0;
        bus_if.start_i = 1'b0;
        bus_if.a_i     = '0;
        bus_if.b_i     = '0;
        repeat (3) @(negedge clk);
        chk("rst_prod", 64'(bus_if.prod_o), 64'd0);
        chk("rst_valid", 64'(bus_if.valid_o), 64'd0);
        chk("rst_busy", 64'(bus_if.busy_o), 64'd0);
        chk("rst_sat", 64'(bus_if.sat_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("one_x_one",  FX_ONE,        FX_ONE,        1'b0);
        run_op("neg_frac",   32'h0030_0000, 32'hFFF0_0000, 1'b0);
        run_op("sat_pos",    32'h7D00_0000, 32'h7D00_0000, 1'b0);
        run_op("min_x_one",  32'h8000_0000, FX_ONE,        1'b0);
        run_op("min_x_m1",   32'h8000_0000, 32'hFFE0_0000, 1'b0);
        run_op("tiny",       32'h0000_0001, 32'h0000_0001, 1'b0);
        run_op("neg_tiny",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("sat_neg",    32'h7D00_0000, 32'h8300_0000, 1'b0);
        run_op("zero_neg",   32'h0000_0000, 32'hFFE0_0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op("rand", 32'($urandom), 32'($urandom_range(32'h00FF_FFFF, 0)) ^
                   (($urandom_range(1, 0) == 1) ? 32'hFF00_0000 : 32'h0), 1'b0);
        end
        run_op("disturb",    FX_ONE,        FX_ONE,        1'b1);

        // Abort a computation with a one-edge reset while BUSY.
        @(negedge clk);
        bus_if.a_i     = 32'h0030_0000;
        bus_if.b_i     = 32'h0050_0000;
        bus_if.start_i = 1'b1;
        @(negedge clk);
        bus_if.start_i = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_valid", 64'(bus_if.valid_o), 64'd0);
        chk("abort_busy", 64'(bus_if.busy_o), 64'd0);
        chk("abort_prod", 64'(bus_if.prod_o), 64'd0);
        extra = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (bus_if.valid_o || bus_if.busy_o) extra++;
        end
        chk("abort_quiet", 64'(extra), 64'd0);
        run_op("after_abort", 32'h0030_0000, 32'h0050_0000, 1'b0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        lat = 0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
